// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer controller: in-order alloc of up to 4/cycle at tail, result capture from 4 forward buses,
// in-order retire of up to 2/cycle from head, squash of younger entries on mispredict flush.
// Latency: forward -> retire decision next cycle -> registered write-port outputs the cycle after.
// Backpressure: alloc_ready (from registered count only) gates allocation; flush suppresses alloc that cycle.
// Ports: clk/rst (sync, active-high); alloc_count/dvalid/dest/pc in, alloc_ready/alloc_base out;
//   fwd_a..fwd_d {valid, idx, value}; flush/flush_idx; wen/waddr/wdata 0/1, commit_cnt, commit_pc0/1;
//   rob_head/rob_tail/rob_count/rob_empty/rob_full status.
// Packed per-slot fields are slot0-first from the MSB end: dest slot0=[11:9], pc slot0=[63:48], dvalid slot0=[3].
module rob_commit_ctrl #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int DATA_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   alloc_count,
  input  logic [3:0]                   alloc_dvalid,
  input  logic [11:0]                  alloc_dest,
  input  logic [63:0]                  alloc_pc,
  output logic                         alloc_ready,
  output logic [IDX_W-1:0]             alloc_base,
  input  logic [IDX_W+DATA_W:0]        fwd_a,
  input  logic [IDX_W+DATA_W:0]        fwd_b,
  input  logic [IDX_W+DATA_W:0]        fwd_c,
  input  logic [IDX_W+DATA_W:0]        fwd_d,
  input  logic                         flush,
  input  logic [IDX_W-1:0]             flush_idx,
  output logic                         wen0,
  output logic                         wen1,
  output logic [2:0]                   waddr0,
  output logic [2:0]                   waddr1,
  output logic [DATA_W-1:0]            wdata0,
  output logic [DATA_W-1:0]            wdata1,
  output logic [1:0]                   commit_cnt,
  output logic [15:0]                  commit_pc0,
  output logic [15:0]                  commit_pc1,
  output logic [IDX_W-1:0]             rob_head,
  output logic [IDX_W-1:0]             rob_tail,
  output logic [IDX_W:0]               rob_count,
  output logic                         rob_empty,
  output logic                         rob_full
);
  localparam int              FWD_W = 1 + IDX_W + DATA_W;
  localparam logic [IDX_W:0]  DEPTH = (IDX_W+1)'(ENTRIES);

  logic [IDX_W-1:0]  head_q, tail_q;
  logic [IDX_W:0]    count_q;
  logic [ENTRIES-1:0] valid_q, ready_q, dvalid_q;
  logic [2:0]        dest_q  [ENTRIES];
  logic [15:0]       pc_q    [ENTRIES];
  logic [DATA_W-1:0] value_q [ENTRIES];

  assign rob_head  = head_q;
  assign rob_tail  = tail_q;
  assign rob_count = count_q;
  assign rob_empty = (count_q == '0);
  assign rob_full  = (count_q == DEPTH);

  // Allocation: space check uses registered count only, so a same-cycle retire never frees room.
  logic [IDX_W:0] cnt_ext, alloc_add;
  logic           alloc_fire;
  assign cnt_ext     = (IDX_W+1)'(alloc_count);
  assign alloc_ready = (DEPTH - count_q) >= cnt_ext;
  assign alloc_base  = tail_q;
  assign alloc_fire  = (alloc_count != 3'd0) && (alloc_count <= 3'd4) && alloc_ready && !flush;
  assign alloc_add   = alloc_fire ? cnt_ext : '0;

  logic        slot_dv   [4];
  logic [2:0]  slot_dest [4];
  logic [15:0] slot_pc   [4];
  for (genvar k = 0; k < 4; k++) begin : g_slot
    assign slot_dv[k]   = alloc_dvalid[3-k];
    assign slot_dest[k] = alloc_dest[11-3*k -: 3];
    assign slot_pc[k]   = alloc_pc[63-16*k -: 16];
  end

  // Retire decision on registered state; head+1 only goes if head goes.
  logic [IDX_W-1:0] head1;
  logic             ret0, ret1, same_dest;
  logic [1:0]       n_ret;
  assign head1     = head_q + IDX_W'(1);
  assign ret0      = valid_q[head_q] & ready_q[head_q];
  assign ret1      = ret0 & valid_q[head1] & ready_q[head1];
  assign n_ret     = {1'b0, ret0} + {1'b0, ret1};
  assign same_dest = ret1 & dvalid_q[head_q] & dvalid_q[head1] & (dest_q[head_q] == dest_q[head1]);

  // Flush: offset from head locates the branch; keep is 1..ENTRIES so a full buffer flushed at head-1 stays full.
  logic [IDX_W-1:0] flush_off;
  logic             flush_hit;
  logic [IDX_W:0]   flush_keep;
  assign flush_off  = flush_idx - head_q;
  assign flush_hit  = flush && ({1'b0, flush_off} < count_q);
  assign flush_keep = {1'b0, flush_off} + (IDX_W+1)'(1);

  logic [FWD_W-1:0] bus [4];
  assign bus[0] = fwd_a;
  assign bus[1] = fwd_b;
  assign bus[2] = fwd_c;
  assign bus[3] = fwd_d;

  logic [ENTRIES-1:0] fwd_set, squash, alloc_set;
  logic [DATA_W-1:0]  fwd_val    [ENTRIES];
  logic [1:0]         alloc_slot [ENTRIES];

  always_comb begin
    logic [IDX_W-1:0] off, aoff;
    off  = '0;
    aoff = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      off           = IDX_W'(i) - head_q;
      aoff          = IDX_W'(i) - tail_q;
      fwd_set[i]    = 1'b0;
      fwd_val[i]    = '0;
      // Buses scanned a..d so the later letter overwrites on an index collision.
      for (int b = 0; b < 4; b++) begin
        if (bus[b][FWD_W-1] && (bus[b][FWD_W-2 -: IDX_W] == IDX_W'(i)) && ({1'b0, off} < count_q)) begin
          fwd_set[i] = 1'b1;
          fwd_val[i] = bus[b][DATA_W-1:0];
        end
      end
      squash[i]     = flush_hit && ({1'b0, off} < count_q) && (off > flush_off);
      alloc_set[i]  = alloc_fire && ({1'b0, aoff} < cnt_ext);
      alloc_slot[i] = aoff[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      ready_q    <= '0;
      wen0       <= 1'b0;
      wen1       <= 1'b0;
      waddr0     <= '0;
      waddr1     <= '0;
      wdata0     <= '0;
      wdata1     <= '0;
      commit_cnt <= '0;
      commit_pc0 <= '0;
      commit_pc1 <= '0;
    end else begin
      head_q <= head_q + IDX_W'(n_ret);
      if (flush_hit) begin
        tail_q  <= flush_idx + IDX_W'(1);
        count_q <= flush_keep - (IDX_W+1)'(n_ret);
      end else begin
        tail_q  <= tail_q + alloc_add[IDX_W-1:0];
        count_q <= count_q + alloc_add - (IDX_W+1)'(n_ret);
      end
      // Priority, lowest first: forward, alloc, retire, squash.
      for (int i = 0; i < ENTRIES; i++) begin
        if (fwd_set[i]) ready_q[i] <= 1'b1;
        if (alloc_set[i]) begin
          valid_q[i] <= 1'b1;
          ready_q[i] <= 1'b0;
        end
      end
      if (ret0) begin
        valid_q[head_q] <= 1'b0;
        ready_q[head_q] <= 1'b0;
      end
      if (ret1) begin
        valid_q[head1] <= 1'b0;
        ready_q[head1] <= 1'b0;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (squash[i]) begin
          valid_q[i] <= 1'b0;
          ready_q[i] <= 1'b0;
        end
      end
      // Same dest on both ports: only the younger write survives.
      wen0       <= ret0 & dvalid_q[head_q] & ~same_dest;
      wen1       <= ret1 & dvalid_q[head1];
      waddr0     <= ret0 ? dest_q[head_q]  : '0;
      waddr1     <= ret1 ? dest_q[head1]   : '0;
      wdata0     <= ret0 ? value_q[head_q] : '0;
      wdata1     <= ret1 ? value_q[head1]  : '0;
      commit_pc0 <= ret0 ? pc_q[head_q]    : '0;
      commit_pc1 <= ret1 ? pc_q[head1]     : '0;
      commit_cnt <= n_ret;
    end
  end

  // Payload needs no reset: it is only observed behind valid/ready.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (fwd_set[i]) value_q[i] <= fwd_val[i];
      if (alloc_set[i]) begin
        dvalid_q[i] <= slot_dv[alloc_slot[i]];
        dest_q[i]   <= slot_dest[alloc_slot[i]];
        pc_q[i]     <= slot_pc[alloc_slot[i]];
      end
    end
  end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: program-order queue model of the ROB, scoreboard of retired entries,
// independent monitor comparing each commit group, plus directed scenarios and a random phase.
module tb_rob_commit_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  alloc_count;
  logic [3:0]  alloc_dvalid;
  logic [11:0] alloc_dest;
  logic [63:0] alloc_pc;
  logic        alloc_ready;
  logic [5:0]  alloc_base;
  logic [22:0] fwd_a, fwd_b, fwd_c, fwd_d;
  logic        flush;
  logic [5:0]  flush_idx;
  logic        wen0, wen1;
  logic [2:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  commit_cnt;
  logic [15:0] commit_pc0, commit_pc1;
  logic [5:0]  rob_head, rob_tail;
  logic [6:0]  rob_count;
  logic        rob_empty, rob_full;

  rob_commit_ctrl dut (
    .clk(clk), .rst(rst),
    .alloc_count(alloc_count), .alloc_dvalid(alloc_dvalid), .alloc_dest(alloc_dest), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_base(alloc_base),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .fwd_d(fwd_d),
    .flush(flush), .flush_idx(flush_idx),
    .wen0(wen0), .wen1(wen1), .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
    .commit_cnt(commit_cnt), .commit_pc0(commit_pc0), .commit_pc1(commit_pc1),
    .rob_head(rob_head), .rob_tail(rob_tail), .rob_count(rob_count), .rob_empty(rob_empty), .rob_full(rob_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] pc;
    bit          dv;
    logic [2:0]  dest;
    logic [15:0] val;
    bit          rdy;
    int          grp;
  } ent_t;

  ent_t rob[$];     // live entries, oldest first
  ent_t exp_q[$];   // retired entries awaiting the monitor
  int   m_head, m_tail;
  int   n_checks, n_fail;
  logic [15:0] pc_ctr = 16'h1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [22:0] fw(input int idx, input logic [15:0] v);
    logic [5:0] i6;
    i6 = 6'(idx);
    return {1'b1, i6, v};
  endfunction

  function automatic bit in_rob(input int idx);
    foreach (rob[i]) if (rob[i].idx == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    alloc_count = 3'd0; alloc_dvalid = 4'd0; alloc_dest = 12'd0; alloc_pc = 64'd0;
    fwd_a = '0; fwd_b = '0; fwd_c = '0; fwd_d = '0;
    flush = 1'b0; flush_idx = 6'd0;
  endtask

  task automatic set_alloc(input int n, input logic [3:0] dv, input logic [11:0] dest);
    alloc_count  = 3'(n);
    alloc_dvalid = dv;
    alloc_dest   = dest;
    alloc_pc     = {pc_ctr, pc_ctr + 16'd1, pc_ctr + 16'd2, pc_ctr + 16'd3};
    pc_ctr       = pc_ctr + 16'd4;
  endtask

  task automatic apply_fwd(input logic [22:0] f);
    if (f[22]) foreach (rob[i]) if (rob[i].idx == int'(f[21:16])) begin
      rob[i].rdy = 1'b1;
      rob[i].val = f[15:0];
    end
  endtask

  // Reference model for one clock edge, using the inputs the DUT just sampled.
  task automatic model_edge();
    int pre, n, fpos;
    pre = rob.size(); n = 0; fpos = -1;
    if (pre > 0 && rob[0].rdy) begin
      n = 1;
      if (pre > 1 && rob[1].rdy) n = 2;
    end
    if (flush) begin
      foreach (rob[i]) if (rob[i].idx == int'(flush_idx)) fpos = i;
      if (fpos >= 0) begin
        while (rob.size() > fpos + 1) void'(rob.pop_back());
        m_tail = (int'(flush_idx) + 1) % 64;
      end
    end
    apply_fwd(fwd_a); apply_fwd(fwd_b); apply_fwd(fwd_c); apply_fwd(fwd_d);
    for (int k = 0; k < n; k++) begin
      ent_t e;
      e = rob.pop_front();
      e.grp = n;
      exp_q.push_back(e);
    end
    m_head = (m_head + n) % 64;
    if (!flush && alloc_count >= 3'd1 && alloc_count <= 3'd4 && (64 - pre) >= int'(alloc_count)) begin
      for (int k = 0; k < int'(alloc_count); k++) begin
        ent_t e;
        e.idx = (m_tail + k) % 64; e.pc = alloc_pc[63-16*k -: 16]; e.dv = alloc_dvalid[3-k];
        e.dest = alloc_dest[11-3*k -: 3]; e.val = 16'd0; e.rdy = 1'b0; e.grp = 0;
        rob.push_back(e);
      end
      m_tail = (m_tail + int'(alloc_count)) % 64;
    end
  endtask

  task automatic step();
    #1;
    chk("alloc_ready", alloc_ready, ((64 - rob.size()) >= int'(alloc_count)) ? 64'd1 : 64'd0);
    chk("alloc_base", alloc_base, m_tail);
    @(posedge clk);
    model_edge();
    #1;
    chk("rob_count", rob_count, rob.size());
    chk("rob_head", rob_head, m_head);
    chk("rob_tail", rob_tail, m_tail);
    chk("rob_empty", rob_empty, (rob.size() == 0) ? 64'd1 : 64'd0);
    chk("rob_full", rob_full, (rob.size() == 64) ? 64'd1 : 64'd0);
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    chk("exp_q_drained", exp_q.size(), 0);
    rst = 1'b1; idle();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_head", rob_head, 0);  chk("rst_tail", rob_tail, 0);  chk("rst_count", rob_count, 0);
    chk("rst_empty", rob_empty, 1); chk("rst_full", rob_full, 0);
    chk("rst_wen", {wen0, wen1}, 0); chk("rst_commit_cnt", commit_cnt, 0);
    chk("rst_wdata", {wdata0, wdata1, 3'd0, waddr0, 3'd0, waddr1}, 0);
    chk("rst_pc", {commit_pc0, commit_pc1}, 0);
    rob.delete(); exp_q.delete(); m_head = 0; m_tail = 0;
    rst = 1'b0;
  endtask

  // Forward up to 4 not-yet-ready entries per cycle until the model is empty.
  task automatic drain_all();
    for (int it = 0; it < 400 && rob.size() > 0; it++) begin
      logic [22:0] f[4];
      int nf;
      nf = 0;
      f[0] = '0; f[1] = '0; f[2] = '0; f[3] = '0;
      foreach (rob[i]) if (!rob[i].rdy && nf < 4) begin
        f[nf] = fw(rob[i].idx, 16'($urandom)); nf++;
      end
      fwd_a = f[0]; fwd_b = f[1]; fwd_c = f[2]; fwd_d = f[3];
      step();
    end
    step(); step();
    chk("drain_empty", rob_empty, 1);
  endtask

  task automatic rand_cycle();
    int nr[$];
    logic [22:0] f[4];
    int r, idx;
    foreach (rob[i]) if (!rob[i].rdy) nr.push_back(rob[i].idx);
    r = $urandom_range(0, 99);
    set_alloc((r < 5) ? $urandom_range(5, 7) : $urandom_range(0, 4), 4'($urandom), 12'($urandom));
    for (int b = 0; b < 4; b++) begin
      f[b] = '0;
      r = $urandom_range(0, 99);
      if (r < 45 && nr.size() > 0) f[b] = fw(nr[$urandom_range(0, nr.size() - 1)], 16'($urandom));
      else if (r < 55) begin
        idx = $urandom_range(0, 63);
        if (!in_rob(idx)) f[b] = fw(idx, 16'($urandom));
      end
    end
    fwd_a = f[0]; fwd_b = f[1]; fwd_c = f[2]; fwd_d = f[3];
    r = $urandom_range(0, 99);
    if (r < 3 && nr.size() > 0) begin
      flush = 1'b1; flush_idx = 6'(nr[$urandom_range(0, nr.size() - 1)]);
    end else if (r < 4) begin
      idx = $urandom_range(0, 63);
      if (!in_rob(idx)) begin flush = 1'b1; flush_idx = 6'(idx); end
    end
  endtask

  // Monitor: compares each presented commit group against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && commit_cnt != 2'd0) begin
        int c;
        c = int'(commit_cnt);
        if (exp_q.size() < c) chk("commit_underflow", exp_q.size(), c);
        else begin
          ent_t e0, e1;
          bit same, w0;
          e0 = exp_q.pop_front();
          chk("commit_cnt", c, e0.grp);
          chk("commit_pc0", commit_pc0, e0.pc);
          same = 1'b0;
          if (c == 2) begin
            e1 = exp_q.pop_front();
            same = e0.dv && e1.dv && (e0.dest == e1.dest);
            chk("commit_pc1", commit_pc1, e1.pc);
            chk("wen1", wen1, e1.dv);
            if (e1.dv) begin chk("waddr1", waddr1, e1.dest); chk("wdata1", wdata1, e1.val); end
          end else chk("wen1_single", wen1, 0);
          w0 = e0.dv && !same;
          chk("wen0", wen0, w0);
          if (w0) begin chk("waddr0", waddr0, e0.dest); chk("wdata0", wdata0, e0.val); end
        end
      end
    end
  end

  initial begin
    idle();
    // 1: basic retire latency
    do_reset();
    set_alloc(4, 4'b1111, {3'd1, 3'd2, 3'd3, 3'd4}); step();
    fwd_a = fw(0, 16'h0005); step();
    step();
    chk("t1_commit_cnt", commit_cnt, 1); chk("t1_wen0", wen0, 1);
    chk("t1_waddr0", waddr0, 1); chk("t1_wdata0", wdata0, 5); chk("t1_head", rob_head, 1);
    // 2: head blocks on a non-ready entry
    fwd_a = fw(2, 16'h0022); step(); step();
    chk("t2_blocked", commit_cnt, 0); chk("t2_head_held", rob_head, 1);
    fwd_a = fw(1, 16'h0011); step(); step();
    chk("t2_commit_cnt", commit_cnt, 2); chk("t2_wen", {wen0, wen1}, 2'b11);
    // 3: full buffer, held request, full flush at head-1, space threshold
    do_reset();
    repeat (16) begin set_alloc(4, 4'($urandom), 12'($urandom)); step(); end
    chk("t3_full", rob_full, 1);
    alloc_count = 3'd1; #1; chk("t3_ready1", alloc_ready, 0);
    set_alloc(4, 4'b1111, 12'hfff); step();
    chk("t3_tail_held", rob_tail, 0);
    flush = 1'b1; flush_idx = 6'd63; step();
    chk("t3_flush_full", rob_count, 64);
    fwd_a = fw(0, 16'h00a0); fwd_b = fw(1, 16'h00a1); step(); step();
    set_alloc(4, 4'b1111, 12'h123); #1; chk("t3_ready4_at62", alloc_ready, 0); step();
    fwd_a = fw(2, 16'h00a2); fwd_b = fw(3, 16'h00a3); step(); step();
    set_alloc(4, 4'b1111, 12'h456); #1; chk("t3_ready4_at60", alloc_ready, 1); step();
    chk("t3_refilled", rob_count, 64);
    // 4: flush truncation, squashed index ignored, allocation resumes at flush_idx+1
    do_reset();
    set_alloc(4, 4'b1111, 12'h111); step();
    set_alloc(4, 4'b1111, 12'h222); step();
    set_alloc(2, 4'b1100, 12'h333); step();
    flush = 1'b1; flush_idx = 6'd4; step();
    chk("t4_tail", rob_tail, 5); chk("t4_count", rob_count, 5);
    fwd_a = fw(7, 16'h0777); step();
    set_alloc(4, 4'b1111, 12'h444); #1; chk("t4_base", alloc_base, 5); step();
    fwd_a = fw(0, 16'h0100); fwd_b = fw(1, 16'h0101); fwd_c = fw(2, 16'h0102); fwd_d = fw(3, 16'h0103); step();
    fwd_a = fw(4, 16'h0104); fwd_b = fw(5, 16'h0105); fwd_c = fw(6, 16'h0106); step();
    repeat (6) step();
    chk("t4_head_stops", rob_head, 7); chk("t4_count_left", rob_count, 2);
    // 5: same destination on both ports
    do_reset();
    set_alloc(2, 4'b1100, {3'd3, 3'd3, 6'd0}); step();
    fwd_a = fw(0, 16'd7); fwd_b = fw(1, 16'd9); step(); step();
    chk("t5_wen0", wen0, 0); chk("t5_wen1", wen1, 1); chk("t5_waddr1", waddr1, 3);
    chk("t5_wdata1", wdata1, 9); chk("t5_commit_cnt", commit_cnt, 2);
    // 6: pointer wrap
    do_reset();
    repeat (15) begin set_alloc(4, 4'b1010, 12'h5a5); step(); end
    set_alloc(2, 4'b1100, 12'h0c0); step();
    drain_all();
    chk("t6_head62", rob_head, 62);
    set_alloc(4, 4'b1111, {3'd1, 3'd2, 3'd3, 3'd4}); step();
    chk("t6_tail_wrap", rob_tail, 2);
    fwd_a = fw(62, 16'h3e); fwd_b = fw(63, 16'h3f); fwd_c = fw(0, 16'h40); fwd_d = fw(1, 16'h41); step(); step();
    chk("t6_first_pair", commit_cnt, 2); chk("t6_head0", rob_head, 0);
    step();
    chk("t6_second_pair", commit_cnt, 2); chk("t6_head2", rob_head, 2); chk("t6_empty", rob_empty, 1);
    // random phase
    do_reset();
    repeat (3000) begin rand_cycle(); step(); end
    drain_all();
    @(negedge clk); #1;
    chk("final_exp_q", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
